// File: rtl/stg_ma.sv
// Memory-address stage: builds the effective address, steers it onto one of two
// memory ports (alternating r_mp) and registers the instruction toward MO.
// Optional capability bounds checking is compiled in with `define MA_BOUNDS_CHECK_EN.
module stg_ma #(
   parameter int SIZE_ADDR = 48,
   parameter int SIZE_DATA = 24,
   parameter int SIZE_OPC  = 6,
   parameter int TGT_GP_W  = 5,
   parameter int TGT_SR_W  = 3,
   parameter int TGT_AR_W  = 3
) (
   input  logic                 iw_clk,
   input  logic                 iw_rst,
   input  logic [SIZE_ADDR-1:0] iw_pc,
   output logic [SIZE_ADDR-1:0] ow_pc,
   input  logic [SIZE_DATA-1:0] iw_instr,
   output logic [SIZE_DATA-1:0] ow_instr,
   input  logic [SIZE_OPC-1:0]  iw_opc,
   output logic [SIZE_OPC-1:0]  ow_opc,
   input  logic [SIZE_OPC-1:0]  iw_root_opc,
   output logic [SIZE_OPC-1:0]  ow_root_opc,
   input  logic [TGT_GP_W-1:0]  iw_tgt_gp,
   input  logic                 iw_tgt_gp_we,
   output logic [TGT_GP_W-1:0]  ow_tgt_gp,
   output logic                 ow_tgt_gp_we,
   input  logic [TGT_SR_W-1:0]  iw_tgt_sr,
   input  logic                 iw_tgt_sr_we,
   output logic [TGT_SR_W-1:0]  ow_tgt_sr,
   output logic                 ow_tgt_sr_we,
   input  logic [TGT_AR_W-1:0]  iw_tgt_ar,
   input  logic                 iw_tgt_ar_we,
   output logic [TGT_AR_W-1:0]  ow_tgt_ar,
   output logic                 ow_tgt_ar_we,
   input  logic [SIZE_DATA-1:0] iw_result,
   output logic [SIZE_DATA-1:0] ow_result,
   input  logic [SIZE_ADDR-1:0] iw_sr_result,
   output logic [SIZE_ADDR-1:0] ow_sr_result,
   input  logic [SIZE_ADDR-1:0] iw_ar_result,
   output logic [SIZE_ADDR-1:0] ow_ar_result,
   input  logic [SIZE_ADDR-1:0] iw_ea_base,
   input  logic [SIZE_DATA-1:0] iw_ea_off,
   input  logic [SIZE_ADDR-1:0] iw_cap_base,
   input  logic [SIZE_ADDR-1:0] iw_cap_len,
   input  logic                 iw_stall,
   input  logic                 iw_flush,
   output logic [SIZE_ADDR-1:0] ow_mem_addr [0:1],
   output logic                 ow_mem_re [0:1],
   output logic                 ow_mem_mp,
   output logic                 ow_trap_pending,
   output logic [SIZE_ADDR-1:0] ow_trap_addr
);

   localparam logic [SIZE_OPC-1:0] OPC_NOP    = SIZE_OPC'(6'h00);
   localparam logic [SIZE_OPC-1:0] OPC_LDCSO  = SIZE_OPC'(6'h10);
   localparam logic [SIZE_OPC-1:0] OPC_STCSO  = SIZE_OPC'(6'h11);
   localparam logic [SIZE_OPC-1:0] OPC_STUI   = SIZE_OPC'(6'h12);
   localparam logic [SIZE_OPC-1:0] OPC_STSI   = SIZE_OPC'(6'h13);
   localparam logic [SIZE_OPC-1:0] OPC_SRLDSO = SIZE_OPC'(6'h14);
   localparam logic [SIZE_OPC-1:0] OPC_SRSTSO = SIZE_OPC'(6'h15);

   logic                 r_mp;
   logic                 mem_op;
   logic                 is_load;
   logic                 two_word;
   logic                 trap;
   logic                 trap_live;
   logic                 squash;
   logic [SIZE_ADDR-1:0] ea;

   assign ea = iw_ea_base + {{(SIZE_ADDR-SIZE_DATA){iw_ea_off[SIZE_DATA-1]}}, iw_ea_off};

   always_comb begin
      mem_op   = 1'b0;
      is_load  = 1'b0;
      two_word = 1'b0;
      case (iw_opc)
         OPC_LDCSO:                       begin mem_op = 1'b1; is_load = 1'b1; end
         OPC_STCSO, OPC_STUI, OPC_STSI:   mem_op = 1'b1;
         OPC_SRLDSO: begin mem_op = 1'b1; is_load = 1'b1; two_word = 1'b1; end
         OPC_SRSTSO: begin mem_op = 1'b1; two_word = 1'b1; end
         default: ;
      endcase
   end

`ifdef MA_BOUNDS_CHECK_EN
   // 49-bit arithmetic so a window or access reaching 2^48 compares correctly.
   logic [SIZE_ADDR:0] ea_end;
   logic [SIZE_ADDR:0] cap_end;
   logic               below;
   logic               above;
   logic               wraps;

   assign ea_end  = {1'b0, ea} + (two_word ? (SIZE_ADDR+1)'(2) : (SIZE_ADDR+1)'(1));
   assign cap_end = {1'b0, iw_cap_base} + {1'b0, iw_cap_len};
   assign below   = ({1'b0, ea} < {1'b0, iw_cap_base});
   assign above   = (ea_end > cap_end);
   assign wraps   = two_word & (&ea);
   assign trap    = mem_op & (below | above | wraps);
`else
   logic unused_cap;
   assign unused_cap = ^{iw_cap_base, iw_cap_len, two_word};
   assign trap       = 1'b0;
`endif

   assign squash    = iw_flush | trap;
   assign trap_live = trap & ~iw_flush;

   // Only the port selected by r_mp carries the access; reset blanks both at once.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic sel;
         assign sel             = mem_op & ~iw_rst & (r_mp == 1'(gi));
         assign ow_mem_addr[gi] = sel ? ea : '0;
         assign ow_mem_re[gi]   = sel & is_load & ~iw_stall & ~trap;
      end
   endgenerate

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         r_mp            <= 1'b0;
         ow_mem_mp       <= 1'b0;
         ow_pc           <= '0;
         ow_instr        <= '0;
         ow_opc          <= OPC_NOP;
         ow_root_opc     <= OPC_NOP;
         ow_tgt_gp       <= '0;
         ow_tgt_gp_we    <= 1'b0;
         ow_tgt_sr       <= '0;
         ow_tgt_sr_we    <= 1'b0;
         ow_tgt_ar       <= '0;
         ow_tgt_ar_we    <= 1'b0;
         ow_result       <= '0;
         ow_sr_result    <= '0;
         ow_ar_result    <= '0;
         ow_trap_pending <= 1'b0;
         ow_trap_addr    <= '0;
      end else if (!iw_stall) begin
         r_mp            <= ~r_mp;
         ow_mem_mp       <= r_mp;
         ow_pc           <= iw_pc;
         ow_instr        <= iw_instr;
         ow_opc          <= squash ? OPC_NOP : iw_opc;
         ow_root_opc     <= iw_flush ? OPC_NOP : iw_root_opc;
         ow_tgt_gp       <= iw_tgt_gp;
         ow_tgt_gp_we    <= iw_tgt_gp_we & ~squash;
         ow_tgt_sr       <= iw_tgt_sr;
         ow_tgt_sr_we    <= iw_tgt_sr_we & ~squash;
         ow_tgt_ar       <= iw_tgt_ar;
         ow_tgt_ar_we    <= iw_tgt_ar_we & ~squash;
         ow_result       <= iw_result;
         ow_sr_result    <= iw_sr_result;
         ow_ar_result    <= iw_ar_result;
         ow_trap_pending <= trap_live;
         ow_trap_addr    <= trap_live ? ea : '0;
      end
   end

endmodule

// File: doc/stg_ma.md
STG_MA -- requirements
Module: stg_ma

Interface
REQ-001 SHALL have port iw_clk, input, 1, clock; all state updates on the rising edge.
REQ-002 SHALL have port iw_rst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have ports iw_pc/ow_pc, in/out, SIZE_ADDR (48), instruction PC, passed through.
REQ-004 SHALL have ports iw_instr/ow_instr, in/out, SIZE_DATA (24), instruction word, passed through.
REQ-005 SHALL have ports iw_opc/ow_opc and iw_root_opc/ow_root_opc, in/out, SIZE_OPC, opcodes.
REQ-006 SHALL have ports iw_tgt_gp/_we, iw_tgt_sr/_we and iw_tgt_ar/_we, with matching ow_* outputs, TGT widths + 1, writeback targets.
REQ-007 SHALL have ports iw_result/ow_result, in/out, 24, GP result or store data.
REQ-008 SHALL have ports iw_sr_result/ow_sr_result and iw_ar_result/ow_ar_result, in/out, 48, SR/AR values.
REQ-009 SHALL have port iw_ea_base, input, 48, address base (AR or capability cursor).
REQ-010 SHALL have port iw_ea_off, input, 24, signed offset.
REQ-011 SHALL have ports iw_cap_base and iw_cap_len, input, 48 each, capability window.
REQ-012 SHALL have ports iw_stall and iw_flush, input, 1 each; hold the stage / insert a bubble.
REQ-013 SHALL have port ow_mem_addr[0:1], output, 48, word address per port.
REQ-014 SHALL have port ow_mem_re[0:1], output, 1, read enable per port.
REQ-015 SHALL have port ow_mem_mp, output, 1, port MO uses next cycle.
REQ-016 SHALL have port ow_trap_pending, output, 1, bounds trap raised toward MO/WB.
REQ-017 SHALL have port ow_trap_addr, output, 48, faulting effective address.

Function
REQ-018 SHALL compute ea = iw_ea_base + sign_extend48(iw_ea_off), modulo 2^48 (wrap, no carry out).
REQ-019 SHALL define mem ops as LDcso, STcso, STui, STsi (size 1 word) and SRLDso, SRSTso (size 2 words); all other opcodes SHALL drive no memory outputs.
REQ-020 SHALL hold port toggle r_mp; when not stalled, r_mp flips every cycle, bubbles included.
REQ-021 SHALL, combinationally for a mem op: ow_mem_addr[r_mp] = ea; ow_mem_re[r_mp] = 1 for loads only; the opposite port's addr and re = 0.
REQ-022 SHALL register ow_mem_mp <= r_mp, so that MO accesses the same port one cycle later.
REQ-023 SHALL register all pass-through signals with 1-cycle latency.
REQ-024 SHALL, on stall: hold every register including r_mp; force ow_mem_re to 0 on both ports.
REQ-025 SHALL, on flush without stall: latch opc/root_opc = NOP and all *_we = 0, clear trap, and still toggle r_mp.
REQ-026 SHALL, when stall and flush are both asserted, give stall priority.
REQ-027 SHALL, on a trap, latch trap_pending = 1 and trap_addr = ea, force all *_we to 0 in the latch, force ow_mem_re = 0, and latch opc = NOP.
REQ-028 SHALL, for a 48-bit op at ea = 2^48-1 (wraps past top), treat the access as a bounds violation.

Reset
REQ-029 SHALL, on iw_rst, asynchronously clear every latch, r_mp, ow_mem_mp and ow_trap_pending to 0; latched opc SHALL equal 0 (NOP).
REQ-030 SHALL abandon any in-flight op when reset is asserted mid-operation; first post-reset edge drives port 0.

Configuration
REQ-031 SHALL, with macro MA_BOUNDS_CHECK_EN defined, trap when ea < cap_base or ea+size > cap_base+cap_len, using 49-bit compare.
REQ-032 SHALL, without MA_BOUNDS_CHECK_EN, never assert ow_trap_pending (tied 0); only REQ-028 wrap is then ignored too; cap inputs unused.

Verification
REQ-033 SHALL cover: LDcso, base=0x100, off=-4, r_mp=0 -> addr[0]=0x0FC, re[0]=1, next cycle ow_mem_mp=0, r_mp=1.
REQ-034 SHALL cover: SRSTso then LDcso back-to-back -> ports alternate 0,1; re=0 for SRSTso, re[1]=1 for LDcso.
REQ-035 SHALL cover: stall held 3 cycles mid-LD -> outputs frozen, re=0, r_mp unchanged, resumes on same port.
REQ-036 SHALL cover: with EN set, cap_base=0x200, len=0x10, SRLDso ea=0x20F -> trap_pending=1, trap_addr=0x20F, all we=0; ea=0x20E -> no trap.
REQ-037 SHALL cover: flush+stall together, then flush alone -> held, then NOP bubble latched, r_mp toggled.
REQ-038 SHALL cover: reset asserted asynchronously mid-cycle during STsi -> all outputs 0 immediately, without waiting for a clock edge.
